// File: rtl/score_keeper_if.sv
// score_keeper_if: game-side bus between the hit/miss pulse stages and the
// score keeper.
//   START      level request to begin or restart a game
//   HIT, MISS  one bit per note column, one-cycle pulses
//   SCORE      binary score (saturating at 9999)
//   COMBO      current hit streak (saturating at 255)
//   MISSES     miss total (saturating at the game-over limit)
//   MULT       current score multiplier
//   PLAYING    game in progress
//   GAME_OVER  game ended by misses
//   SCORE_BCD  four BCD digits of SCORE, present only when BCD_SCORE_EN
//              is defined
// Modports: master = pulse source / display side, slave = score_keeper.
interface score_keeper_if #(
   parameter int unsigned COLS = 4
);
   logic            START;
   logic [COLS-1:0] HIT;
   logic [COLS-1:0] MISS;
   logic [13:0]     SCORE;
   logic [7:0]      COMBO;
   logic [7:0]      MISSES;
   logic [2:0]      MULT;
   logic            PLAYING;
   logic            GAME_OVER;
`ifdef BCD_SCORE_EN
   logic [15:0]     SCORE_BCD;
`endif

   modport master (
`ifdef BCD_SCORE_EN
      input  SCORE_BCD,
`endif
      output START, HIT, MISS,
      input  SCORE, COMBO, MISSES, MULT, PLAYING, GAME_OVER
   );

   modport slave (
`ifdef BCD_SCORE_EN
      output SCORE_BCD,
`endif
      input  START, HIT, MISS,
      output SCORE, COMBO, MISSES, MULT, PLAYING, GAME_OVER
   );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: tallies per-column hit/miss pulses into a score with a combo
// multiplier, a miss count and a combo streak, and runs the IDLE/PLAY/OVER
// game state machine.
// Ports:
//   CLOCK  rising-edge clock for all state
//   RESET  synchronous active-high reset, clears everything
//   bus    score_keeper_if.slave: START, HIT, MISS in; SCORE, COMBO, MISSES,
//          MULT, PLAYING, GAME_OVER out (plus SCORE_BCD when enabled)
// Optional feature: define BCD_SCORE_EN to add SCORE_BCD, the score as four
// BCD digits, registered one cycle after SCORE.
module score_keeper #(
   parameter int unsigned COLS       = 4,
   parameter int unsigned MAX_MISSES = 8,
   parameter int unsigned COMBO_STEP = 8,
   parameter int unsigned MAX_MULT   = 4
) (
   input  logic          CLOCK,
   input  logic          RESET,
   score_keeper_if.slave bus
);

   localparam int unsigned SCORE_W   = 14;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned MULT_W    = 3;
   localparam int unsigned SUM_W     = 16;
   localparam int unsigned SCORE_MAX = 9999;
   localparam int unsigned COMBO_MAX = 255;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_OVER = 2'd2
   } state_t;

   state_t             state_q,   state_d;
   logic [SCORE_W-1:0] score_q,   score_d;
   logic [CNT_W-1:0]   combo_q,   combo_d;
   logic [CNT_W-1:0]   misses_q,  misses_d;
   logic [MULT_W-1:0]  mult_q,    mult_d;
   logic               playing_q, playing_d;
   logic               over_q,    over_d;

   logic [SUM_W-1:0]   nhit;
   logic [SUM_W-1:0]   nmiss;
   logic [SUM_W-1:0]   score_sum;
   logic [SUM_W-1:0]   combo_sum;
   logic [SUM_W-1:0]   miss_sum;
   logic [SCORE_W-1:0] score_sat;
   logic [CNT_W-1:0]   combo_sat;
   logic [CNT_W-1:0]   miss_sat;

   // Number of set bits in a column vector.
   function automatic logic [SUM_W-1:0] popcount(input logic [COLS-1:0] v);
      logic [SUM_W-1:0] n;
      n = '0;
      for (int i = 0; i < int'(COLS); i++) begin
         n = n + SUM_W'(v[i]);
      end
      return n;
   endfunction

   // Multiplier implied by a streak length, capped at MAX_MULT.
   function automatic logic [MULT_W-1:0] mult_of(input logic [CNT_W-1:0] c);
      int unsigned m;
      m = 32'(c) / COMBO_STEP + 32'd1;
      if (m > MAX_MULT) begin
         m = MAX_MULT;
      end
      return MULT_W'(m);
   endfunction

   // Per-cycle tallies and saturating sums; a column with both pulses is a miss.
   always_comb begin
      nhit      = popcount(bus.HIT & ~bus.MISS);
      nmiss     = popcount(bus.MISS);
      score_sum = SUM_W'(score_q) + nhit * SUM_W'(mult_q);
      combo_sum = SUM_W'(combo_q) + nhit;
      miss_sum  = SUM_W'(misses_q) + nmiss;
      score_sat = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                  : SCORE_W'(score_sum);
      combo_sat = (combo_sum > SUM_W'(COMBO_MAX)) ? CNT_W'(COMBO_MAX)
                                                  : CNT_W'(combo_sum);
      miss_sat  = (miss_sum > SUM_W'(MAX_MISSES)) ? CNT_W'(MAX_MISSES)
                                                  : CNT_W'(miss_sum);
   end

   // Next-state and next-counter logic.
   always_comb begin
      state_d  = state_q;
      score_d  = score_q;
      combo_d  = combo_q;
      misses_d = misses_q;

      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               state_d  = S_PLAY;
               score_d  = '0;
               combo_d  = '0;
               misses_d = '0;
            end
         end

         S_PLAY: begin
            score_d  = score_sat;
            combo_d  = (nmiss != '0) ? '0 : combo_sat;
            misses_d = miss_sat;
            // Game-ending miss wins over a restart request in the same cycle.
            if (miss_sat == CNT_W'(MAX_MISSES)) begin
               state_d = S_OVER;
            end else if (bus.START) begin
               score_d  = '0;
               combo_d  = '0;
               misses_d = '0;
            end
         end

         S_OVER: begin
            if (bus.START) begin
               state_d  = S_PLAY;
               score_d  = '0;
               combo_d  = '0;
               misses_d = '0;
            end
         end

         default: begin
            state_d  = S_IDLE;
            score_d  = '0;
            combo_d  = '0;
            misses_d = '0;
         end
      endcase

      // Registered alongside the counters so they track the state register.
      mult_d    = mult_of(combo_d);
      playing_d = (state_d == S_PLAY);
      over_d    = (state_d == S_OVER);
   end

   // State and output registers.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         score_q   <= '0;
         combo_q   <= '0;
         misses_q  <= '0;
         mult_q    <= MULT_W'(1);
         playing_q <= 1'b0;
         over_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         score_q   <= score_d;
         combo_q   <= combo_d;
         misses_q  <= misses_d;
         mult_q    <= mult_d;
         playing_q <= playing_d;
         over_q    <= over_d;
      end
   end

   assign bus.SCORE     = score_q;
   assign bus.COMBO     = combo_q;
   assign bus.MISSES    = misses_q;
   assign bus.MULT      = mult_q;
   assign bus.PLAYING   = playing_q;
   assign bus.GAME_OVER = over_q;

`ifdef BCD_SCORE_EN
   localparam int unsigned BCD_W = 16;

   logic [BCD_W-1:0] bcd_q;

   // Double-dabble: shift binary in, add 3 to any digit >= 5 before each shift.
   function automatic logic [BCD_W-1:0] to_bcd(input logic [SCORE_W-1:0] bin);
      logic [BCD_W+SCORE_W-1:0] sh;
      sh = {BCD_W'(0), bin};
      for (int i = 0; i < int'(SCORE_W); i++) begin
         for (int d = 0; d < 4; d++) begin
            if (sh[int'(SCORE_W) + 4*d +: 4] >= 4'd5) begin
               sh[int'(SCORE_W) + 4*d +: 4] = sh[int'(SCORE_W) + 4*d +: 4] + 4'd3;
            end
         end
         sh = sh << 1;
      end
      return sh[BCD_W+SCORE_W-1:SCORE_W];
   endfunction

   // BCD view of the registered score, one cycle behind it.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         bcd_q <= '0;
      end else begin
         bcd_q <= to_bcd(score_q);
      end
   end

   assign bus.SCORE_BCD = bcd_q;
`endif

endmodule
